// File: rtl/image_pkg.sv
// Shared image geometry and readout FSM state type; highlight and readout
// both use these so they agree on the raster address map.
package image_pkg;

  localparam int unsigned ImgWidth  = 1280;
  localparam int unsigned ImgHeight = 720;
  localparam int unsigned ImgSize   = ImgWidth * ImgHeight;
  localparam int unsigned PixelBits = 24;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } readout_state_e;

  // Address width for an n-entry memory; never returns zero.
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_skid_buffer.sv
// Absorbs 1-cycle BRAM read latency against FIFO backpressure with a single
// skid register; the skid always drains before newer read data.
module bram_skid_buffer
  import image_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = PixelBits
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue,
  input  logic [PIXEL_BITS-1:0] bram_rd_data,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [PIXEL_BITS-1:0] out_din,
  output logic                  rd_valid,
  output logic                  skid_valid
);

  logic                  rd_valid_q, rd_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [PIXEL_BITS-1:0] skid_data_q, skid_data_d;
  logic                  capture;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      rd_valid_q   <= rd_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  always_comb begin
    out_wr_en    = !out_full && (skid_valid_q || rd_valid_q);
    // Read data that cannot be written this cycle must be parked.
    capture      = rd_valid_q && (out_full || skid_valid_q);
    rd_valid_d   = issue;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (capture) begin
      skid_valid_d = 1'b1;
      skid_data_d  = bram_rd_data;
    end else if (skid_valid_q && out_wr_en) begin
      skid_valid_d = 1'b0;
    end
    if (skid_valid_q) begin
      out_din = skid_data_q;
    end else if (rd_valid_q) begin
      out_din = bram_rd_data;
    end else begin
      out_din = '0;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign skid_valid = skid_valid_q;

endmodule

// File: rtl/image_readout.sv
// Reads the finished frame out of the image BRAM once per start and streams
// it in raster order into the output FIFO.
module image_readout
  import image_pkg::*;
#(
  parameter int unsigned WIDTH      = ImgWidth,
  parameter int unsigned HEIGHT     = ImgHeight,
  parameter int unsigned IMAGE_SIZE = WIDTH * HEIGHT,
  parameter int unsigned PIXEL_BITS = PixelBits,
  localparam int unsigned AddrBits  = addr_bits(IMAGE_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [AddrBits-1:0]   bram_rd_addr,
  input  logic [PIXEL_BITS-1:0] bram_rd_data,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic [PIXEL_BITS-1:0] out_din,
  output logic                  busy,
  output logic                  readout_done
);

  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(IMAGE_SIZE - 1);

  readout_state_e      state_q, state_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic                issue;
  logic                rd_valid;
  logic                skid_valid;
  logic                drained;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Nothing in flight after this cycle: either nothing held, or the single
  // held pixel (rd_valid and skid_valid are exclusive) is written now.
  assign drained = !(rd_valid || skid_valid) || out_wr_en;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          addr_d  = '0;
        end
      end
      StRead: begin
        if (issue) begin
          if (addr_q == LastAddr) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (drained) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        addr_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    issue        = (state_q == StRead) && !out_full && !skid_valid;
    busy         = (state_q == StRead) || (state_q == StDrain);
    readout_done = (state_q == StDone);
    bram_rd_addr = addr_q;
  end

  bram_skid_buffer #(
    .PIXEL_BITS (PIXEL_BITS)
  ) u_skid (
    .clock        (clock),
    .reset        (reset),
    .issue        (issue),
    .bram_rd_data (bram_rd_data),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_din      (out_din),
    .rd_valid     (rd_valid),
    .skid_valid   (skid_valid)
  );

endmodule

// File: tb/tb_image_readout.sv
// Randomized self-checking bench for image_readout on an 8x4 frame with a
// behavioural BRAM and an in-order scoreboard.
module tb_image_readout;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int PB = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          out_full = 1'b0;
  logic [4:0]    bram_rd_addr;
  logic [PB-1:0] bram_rd_data = '0;
  logic          out_wr_en;
  logic [PB-1:0] out_din;
  logic          busy;
  logic          readout_done;

  image_readout #(
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bram_rd_addr (bram_rd_addr),
    .bram_rd_data (bram_rd_data),
    .out_full     (out_full),
    .out_wr_en    (out_wr_en),
    .out_din      (out_din),
    .busy         (busy),
    .readout_done (readout_done)
  );

  always #5 clock = ~clock;

  logic [PB-1:0] mem [N];
  always @(posedge clock) bram_rd_data <= mem[bram_rd_addr];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Observation state, filled by the monitor.
  logic [PB-1:0] got_q[$];
  int            got_cyc[$];
  int            done_cnt, done_cyc;
  int            busy_cnt, busy_first, busy_last;
  int            start_cyc;
  int            addr_log [64];
  int            inv_err = 0;
  int            addr_err = 0;
  logic          prev_busy = 1'b0;
  logic [4:0]    prev_addr = '0;

  always @(negedge clock) begin
    if (out_wr_en) begin
      got_q.push_back(out_din);
      got_cyc.push_back(cyc);
    end
    if (readout_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
    if (cyc - start_cyc >= 0 && cyc - start_cyc < 64) addr_log[cyc - start_cyc] = bram_rd_addr;
    if (dut.rd_valid && dut.skid_valid) inv_err++;
    if (busy && prev_busy && bram_rd_addr < prev_addr) addr_err++;
    prev_busy = busy;
    prev_addr = bram_rd_addr;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got %0d required finish", cyc);
    $fatal(1);
  end

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < N; i++) mem[i] = ramp ? PB'(i) : PB'($urandom());
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
    busy_cnt = 0;
    busy_first = -1;
    busy_last = -1;
    for (int i = 0; i < 64; i++) addr_log[i] = -1;
  endtask

  // Reference: the frame must come out exactly as stored, in raster order.
  function automatic int seq_errors();
    int e = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (i >= N || got_q[i] !== mem[i]) e++;
    end
    return e;
  endfunction

  // Modes: 0 free-run, 1 stall at pixel 5, 2 random full, 3 full at start,
  // 4 extra start pulses mid-frame and in DONE.
  task automatic run_frame(input int mode);
    int rel;
    @(posedge clock); #1;
    clear_obs();
    start_cyc = cyc;
    start = 1'b1;
    out_full = (mode == 3);
    for (int k = 0; k < 300; k++) begin
      @(posedge clock); #1;
      rel = cyc - start_cyc;
      start = (mode == 4) && (rel == 10 || rel == 34);
      case (mode)
        1:       out_full = (rel >= 7 && rel <= 9);
        2:       out_full = 1'($urandom_range(0, 1));
        3:       out_full = (rel <= 4);
        default: out_full = 1'b0;
      endcase
      if (done_cnt > 0 && cyc - done_cyc >= 3) break;
    end
    start = 1'b0;
    out_full = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (out_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b required 0", out_wr_en); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (readout_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", readout_done); end
    n_cmp++; if (bram_rd_addr !== 5'd0) begin n_bad++; $display("FAIL reset_addr: got %0d required 0", bram_rd_addr); end
    n_cmp++; if (out_din !== '0) begin n_bad++; $display("FAIL reset_din: got %h required 0", out_din); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int terr = 0;
    fill_mem(1'b1);
    run_frame(0);
    for (int i = 0; i < got_cyc.size(); i++) if (got_cyc[i] - start_cyc != i + 2) terr++;
    n_cmp++; if (got_q.size() !== N) begin n_bad++; $display("FAIL basic_count: got %0d required %0d", got_q.size(), N); end
    n_cmp++; if (seq_errors() !== 0) begin n_bad++; $display("FAIL basic_order: got %0d bad pixels required 0", seq_errors()); end
    n_cmp++; if (terr !== 0) begin n_bad++; $display("FAIL basic_timing: got %0d off-cycle writes required 0", terr); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d required 1", done_cnt); end
    n_cmp++; if (done_cyc - start_cyc !== N + 2) begin n_bad++; $display("FAIL basic_done_cyc: got %0d required %0d", done_cyc - start_cyc, N + 2); end
    n_cmp++; if (busy_first - start_cyc !== 1) begin n_bad++; $display("FAIL basic_busy_first: got %0d required 1", busy_first - start_cyc); end
    n_cmp++; if (busy_last - start_cyc !== N + 1) begin n_bad++; $display("FAIL basic_busy_last: got %0d required %0d", busy_last - start_cyc, N + 1); end
    n_cmp++; if (busy_cnt !== N + 1) begin n_bad++; $display("FAIL basic_busy_cnt: got %0d required %0d", busy_cnt, N + 1); end
  endtask

  task automatic test_stall();
    int p5;
    fill_mem(1'b1);
    run_frame(1);
    p5 = (got_cyc.size() > 5) ? got_cyc[5] - start_cyc : -1;
    n_cmp++; if (got_q.size() !== N) begin n_bad++; $display("FAIL stall_count: got %0d required %0d", got_q.size(), N); end
    n_cmp++; if (seq_errors() !== 0) begin n_bad++; $display("FAIL stall_order: got %0d bad pixels required 0", seq_errors()); end
    n_cmp++; if (p5 !== 10) begin n_bad++; $display("FAIL stall_pix5_cyc: got %0d required 10", p5); end
    n_cmp++; if (addr_log[10] !== addr_log[7]) begin n_bad++; $display("FAIL stall_addr_held: got %0d required %0d", addr_log[10], addr_log[7]); end
    n_cmp++; if (done_cyc - start_cyc !== N + 6) begin n_bad++; $display("FAIL stall_done_cyc: got %0d required %0d", done_cyc - start_cyc, N + 6); end
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stall_done_cnt: got %0d required 1", done_cnt); end
  endtask

  task automatic test_random_full();
    for (int r = 0; r < 3; r++) begin
      fill_mem(1'b0);
      run_frame(2);
      n_cmp++; if (got_q.size() !== N) begin n_bad++; $display("FAIL rand%0d_count: got %0d required %0d", r, got_q.size(), N); end
      n_cmp++; if (seq_errors() !== 0) begin n_bad++; $display("FAIL rand%0d_order: got %0d bad pixels required 0", r, seq_errors()); end
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL rand%0d_done_cnt: got %0d required 1", r, done_cnt); end
    end
    n_cmp++; if (inv_err !== 0) begin n_bad++; $display("FAIL rd_skid_exclusive: got %0d overlaps required 0", inv_err); end
    n_cmp++; if (addr_err !== 0) begin n_bad++; $display("FAIL addr_monotonic: got %0d wraps required 0", addr_err); end
  endtask

  task automatic test_full_at_start();
    fill_mem(1'b0);
    run_frame(3);
    n_cmp++; if (got_cyc.size() == 0 || got_cyc[0] - start_cyc !== 6) begin
      n_bad++; $display("FAIL fullstart_first: got %0d required 6", (got_cyc.size() == 0) ? -1 : got_cyc[0] - start_cyc);
    end
    n_cmp++; if (seq_errors() !== 0 || got_q.size() !== N) begin n_bad++; $display("FAIL fullstart_seq: got %0d px %0d bad required %0d px 0 bad", got_q.size(), seq_errors(), N); end
    n_cmp++; if (done_cyc - start_cyc !== N + 6) begin n_bad++; $display("FAIL fullstart_done_cyc: got %0d required %0d", done_cyc - start_cyc, N + 6); end
  endtask

  task automatic test_reset_midframe();
    int n_at;
    fill_mem(1'b0);
    @(posedge clock); #1;
    clear_obs();
    start_cyc = cyc;
    start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (got_q.size() >= 10) break;
    end
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++; if ({out_wr_en, busy, readout_done} !== 3'b000) begin n_bad++; $display("FAIL midreset_ctrl: got %b required 000", {out_wr_en, busy, readout_done}); end
    n_cmp++; if (bram_rd_addr !== 5'd0 || out_din !== '0) begin n_bad++; $display("FAIL midreset_data: got addr %0d din %h required 0 0", bram_rd_addr, out_din); end
    n_at = got_q.size();
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    n_cmp++; if (got_q.size() !== n_at) begin n_bad++; $display("FAIL midreset_no_wr: got %0d writes required %0d", got_q.size(), n_at); end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d required 0", done_cnt); end
    run_frame(0);
    n_cmp++; if (got_q.size() !== N || seq_errors() !== 0) begin n_bad++; $display("FAIL midreset_refetch: got %0d px %0d bad required %0d px 0 bad", got_q.size(), seq_errors(), N); end
  endtask

  task automatic test_restart_ignored();
    fill_mem(1'b0);
    run_frame(4);
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL restart_done_cnt: got %0d required 1", done_cnt); end
    n_cmp++; if (got_q.size() !== N || seq_errors() !== 0) begin n_bad++; $display("FAIL restart_seq: got %0d px %0d bad required %0d px 0 bad", got_q.size(), seq_errors(), N); end
    n_cmp++; if (busy_cnt !== N + 1) begin n_bad++; $display("FAIL restart_busy_cnt: got %0d required %0d", busy_cnt, N + 1); end
  endtask

  initial begin
    clear_obs();
    start_cyc = 0;
    fill_mem(1'b1);
    test_reset();
    test_basic();
    test_stall();
    test_random_full();
    test_full_at_start();
    test_reset_midframe();
    test_restart_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
